// File: rtl/data_bus_router_n.sv
// Data-side interconnect between the CPU data port and NUM_SLAVES memory-mapped
// targets: address-window decode, shared request bus, fixed-latency read
// response pipeline and unmapped-access error reporting.
module data_bus_router_n #(
    parameter int                             NUM_SLAVES   = 4,
    parameter int                             ADDR_W       = 32,
    parameter int                             DATA_W       = 32,
    parameter int                             RESP_LATENCY = 1,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLAVE_BASE   = {32'hC000_0000, 32'hB000_0000,
                                                             32'hA000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLAVE_MASK   = {32'hFF00_0000, 32'hFFFF_F000,
                                                             32'hFFFF_0000, 32'hF000_0000},
    parameter logic [DATA_W-1:0]              ERR_RDATA    = 32'hDEAD_BEEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W-1:0]            data_addr,
    input  logic                         data_ren,
    input  logic                         data_wen,
    input  logic [DATA_W-1:0]            data_wr,
    input  logic [DATA_W/8-1:0]          data_wstrb,
    output logic [DATA_W-1:0]            data_rd,
    output logic                         data_rvalid,
    output logic                         data_err,
    output logic [ADDR_W-1:0]            common_addr,
    output logic [DATA_W-1:0]            common_wdata,
    output logic [DATA_W/8-1:0]          common_wstrb,
    output logic [NUM_SLAVES-1:0]        slv_ren,
    output logic [NUM_SLAVES-1:0]        slv_wen,
    input  logic [NUM_SLAVES*DATA_W-1:0] slv_rdata,
    output logic [15:0]                  err_count,
    output logic [ADDR_W-1:0]            err_addr
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int LAST  = RESP_LATENCY - 1;

    logic                  hit_any;
    logic [IDX_W-1:0]      sel_idx;
    logic [NUM_SLAVES-1:0] sel_onehot;
    logic                  rd_req;
    logic                  miss_access;
    logic                  write_err_q;

    logic                  pipe_valid [RESP_LATENCY];
    logic [IDX_W-1:0]      pipe_idx   [RESP_LATENCY];
    logic                  pipe_err   [RESP_LATENCY];

    // A read that arrives together with a write is dropped entirely.
    assign rd_req      = data_ren & ~data_wen;
    assign miss_access = (rd_req | data_wen) & ~hit_any;

    // Request path is a pure pass-through so slaves see the access this cycle.
    assign common_addr  = data_addr;
    assign common_wdata = data_wr;
    assign common_wstrb = data_wstrb;

    // Window decode; scanning from the top down lets the lowest index win overlaps.
    always_comb begin
        hit_any = 1'b0;
        sel_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((data_addr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
                hit_any = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
    end

    // One-hot slave select, empty on a miss so unmapped accesses reach no slave.
    always_comb begin
        sel_onehot = '0;
        if (hit_any) begin
            sel_onehot[sel_idx] = 1'b1;
        end
    end

    // Slave enables are held off while reset is asserted.
    assign slv_ren = {NUM_SLAVES{rd_req   & ~rst}} & sel_onehot;
    assign slv_wen = {NUM_SLAVES{data_wen & ~rst}} & sel_onehot;

    // Response pipeline: stage 0 captures every read, all stages shift each cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < RESP_LATENCY; s++) begin
                pipe_valid[s] <= 1'b0;
                pipe_idx[s]   <= '0;
                pipe_err[s]   <= 1'b0;
            end
        end else begin
            pipe_valid[0] <= rd_req;
            pipe_idx[0]   <= sel_idx;
            pipe_err[0]   <= ~hit_any;
            for (int s = 1; s < RESP_LATENCY; s++) begin
                pipe_valid[s] <= pipe_valid[s-1];
                pipe_idx[s]   <= pipe_idx[s-1];
                pipe_err[s]   <= pipe_err[s-1];
            end
        end
    end

    // Return the selected slave's data, or the error pattern for an unmapped read.
    always_comb begin
        data_rd = '0;
        if (pipe_valid[LAST]) begin
            if (pipe_err[LAST]) begin
                data_rd = ERR_RDATA;
            end else begin
                data_rd = slv_rdata[pipe_idx[LAST]*DATA_W +: DATA_W];
            end
        end
    end

    assign data_rvalid = pipe_valid[LAST];
    assign data_err    = (pipe_valid[LAST] & pipe_err[LAST]) | write_err_q;

    // Unmapped writes are flagged one cycle after the request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_err_q <= 1'b0;
        end else begin
            write_err_q <= data_wen & ~hit_any;
        end
    end

    // Saturating error counter and last-error address capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= 16'h0000;
            err_addr  <= '0;
        end else if (miss_access) begin
            if (err_count != 16'hFFFF) begin
                err_count <= err_count + 16'd1;
            end
            err_addr <= data_addr;
        end
    end

endmodule

// File: doc/data_bus_router_n.md
Name: data_bus_router_n

Overview:
Parametrised data-side interconnect between the CPU data port and NUM_SLAVES memory-mapped targets (data memory, devices, timers).
- Decodes each access against per-slave base/mask windows and fans control out on a shared address/wdata/wstrb bus.
- Tracks outstanding reads through a RESP_LATENCY-deep response pipeline, so read data from the correct slave returns with a valid strobe.
- Reports unmapped accesses through an error pulse, a saturating error counter and a last-error address register.

Parameters:
NUM_SLAVES, 4, number of target ports (1..8)
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8)
RESP_LATENCY, 1, cycles from slave ren to slave rdata valid (1..4)
SLAVE_BASE, {32'hC000_0000, 32'hB000_0000, 32'hA000_0000, 32'h0000_0000}, packed NUM_SLAVES*ADDR_W; slice i = base of slave i
SLAVE_MASK, {32'hFF00_0000, 32'hFFFF_F000, 32'hFFFF_0000, 32'hF000_0000}, packed NUM_SLAVES*ADDR_W; slice i = mask of slave i
ERR_RDATA, 32'hDEAD_BEEF, read data returned on an unmapped read

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
data_addr  input  ADDR_W  CPU access address
data_ren  input  1  CPU read request, one per cycle
data_wen  input  1  CPU write request
data_wr  input  DATA_W  CPU write data
data_wstrb  input  DATA_W/8  byte strobes
data_rd  output  DATA_W  read data, valid with data_rvalid
data_rvalid  output  1  read response strobe
data_err  output  1  unmapped-access pulse
common_addr  output  ADDR_W  shared slave address
common_wdata  output  DATA_W  shared slave write data
common_wstrb  output  DATA_W/8  shared slave strobes
slv_ren  output  NUM_SLAVES  per-slave read enable
slv_wen  output  NUM_SLAVES  per-slave write enable
slv_rdata  input  NUM_SLAVES*DATA_W  per-slave read data, valid RESP_LATENCY cycles after slv_ren
err_count  output  16  saturating count of unmapped accesses
err_addr  output  ADDR_W  address of most recent unmapped access

Behaviour:
- Decode (combinational): hit[i] = ((data_addr & MASK[i]) == BASE[i]).
  - Lowest index wins on overlap.
  - miss = no hit.
- common_addr/wdata/wstrb pass data_addr/data_wr/data_wstrb through combinationally. No latency on the request path.
- Write: slv_wen[sel] = data_wen & hit.
- Read: slv_ren[sel] = data_ren & hit & ~data_wen.
- ren and wen asserted together: treated as write only. No read is issued, no read response is produced, and no error is raised for the dropped read.
- Response pipeline:
  - RESP_LATENCY stages, each holding {valid, idx[clog2(NUM_SLAVES)], err}.
  - Stage 0 loads on every read request (mapped or not); all stages shift every cycle.
  - Back-to-back reads are accepted every cycle with no stall.
- Output stage (last pipeline stage, combinational mux):
  - data_rvalid = stage.valid.
  - data_rd = slv_rdata[idx] if valid & ~err; ERR_RDATA if valid & err; 0 when not valid.
- data_err = (last stage valid & err) | write_err_q.
  - write_err_q is a register set by an unmapped write, one cycle after the request.
  - Both sources in the same cycle produce a single-cycle assertion.
- Unmapped access (read or write) in cycle N:
  - err_count increments at the N edge and saturates at 16'hFFFF (no wrap).
  - err_addr <= data_addr at the same edge.
  - Nothing is driven to any slave.
- Reset (asynchronous, any time):
  - Pipeline valid bits, write_err_q and err_count clear to 0; err_addr clears to 0.
  - data_rvalid, data_err, data_rd = 0 immediately.
  - slv_ren/slv_wen follow inputs combinationally, but are forced to 0 while rst is high.
  - Reads in flight at reset are discarded; no late response is produced.

Test Plan:
- Reset, then read 0x0000_0010 with slave0 returning 0x1234_5678 one cycle later -> slv_ren=4'b0001; next cycle data_rvalid=1, data_rd=0x1234_5678, data_err=0.
- Write 0xA000_0004 with data 0xCAFEF00D, strb 4'b0011 -> slv_wen=4'b0010, common_wstrb=4'b0011, no rvalid, err_count unchanged.
- Four back-to-back reads to slaves 0,1,2,3 at RESP_LATENCY=2 -> rvalid high for 4 consecutive cycles starting 2 cycles after the first read, returning each slave's data in order.
- Read 0x5000_0000 (unmapped) -> no slv_ren; next cycle data_rvalid=1, data_rd=0xDEAD_BEEF, data_err=1; err_count=1, err_addr=0x5000_0000.
- ren and wen together at 0xB000_0008 -> only slv_wen[2]=1, no rvalid. Force err_count to 0xFFFF, then an unmapped write -> count stays 0xFFFF and data_err pulses.
- Issue a read, assert rst mid-flight for 1 cycle -> no data_rvalid after release; all outputs 0 during reset.
